// File: rtl/draw_sched_if.sv
// draw_sched_if: requester job bus and draw-engine command bus of the scheduler
interface draw_sched_if;
    logic [2:0]  req;
    logic [5:0]  req_kind;
    logic [23:0] req_px;
    logic [23:0] req_py;
    logic [2:0]  grant;
    logic [2:0]  ack;
    logic [3:0]  eng_cmd;
    logic [7:0]  eng_px;
    logic [7:0]  eng_py;
    logic        eng_done;
    logic        busy;
    logic        timeout_err;
    modport master (
        output req, req_kind, req_px, req_py, eng_done,
        input  grant, ack, eng_cmd, eng_px, eng_py, busy, timeout_err
    );
    modport slave (
        input  req, req_kind, req_px, req_py, eng_done,
        output grant, ack, eng_cmd, eng_px, eng_py, busy, timeout_err
    );
endinterface

// File: rtl/draw_sched.sv
// draw_sched: round-robin owner of the single pixel-draw engine for three level FSMs
module draw_sched #(
    parameter int TIMEOUT = 20000
) (
    input logic        clk,
    input logic        reset,
    draw_sched_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);
    state_t      state_q, state_d;
    logic [1:0]  rr_last_q, rr_last_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  grant_q, grant_d;
    logic [2:0]  ack_q, ack_d;
    logic [3:0]  cmd_q, cmd_d;
    logic [7:0]  px_q, px_d;
    logic [7:0]  py_q, py_d;
    logic        busy_q, busy_d;
    logic        terr_q, terr_d;
    logic [1:0]  idx0, idx1, idx2, win;
    function automatic logic [1:0] nxt(input logic [1:0] x);
        return (x == 2'd2) ? 2'd0 : x + 2'd1;
    endfunction
    // Round-robin winner: first requester after the previous owner, wrapping mod 3
    always_comb begin
        idx0 = nxt(rr_last_q);
        idx1 = nxt(idx0);
        idx2 = nxt(idx1);
        win  = bus.req[idx0] ? idx0 : bus.req[idx1] ? idx1 : idx2;
    end
    // Next-state logic: grant and latch a job in IDLE, hold it until done or timeout, then ack once
    always_comb begin
        state_d   = state_q;
        rr_last_d = rr_last_q;
        cnt_d     = cnt_q;
        grant_d   = grant_q;
        ack_d     = 3'b000;
        cmd_d     = cmd_q;
        px_d      = px_q;
        py_d      = py_q;
        busy_d    = busy_q;
        terr_d    = terr_q;
        unique case (state_q)
            IDLE: begin
                if (|bus.req) begin
                    state_d   = BUSY;
                    rr_last_d = win;
                    cnt_d     = 16'd0;
                    grant_d   = 3'b001 << win;
                    cmd_d     = 4'b0001 << bus.req_kind[{win, 1'b0} +: 2];
                    px_d      = bus.req_px[{win, 3'b000} +: 8];
                    py_d      = bus.req_py[{win, 3'b000} +: 8];
                    busy_d    = 1'b1;
                end else begin
                    grant_d = 3'b000;
                    cmd_d   = 4'b0000;
                    px_d    = 8'd0;
                    py_d    = 8'd0;
                    busy_d  = 1'b0;
                end
            end
            BUSY: begin
                cnt_d = cnt_q + 16'd1;
                if (bus.eng_done || cnt_q == TO_LAST) begin
                    state_d = ACK;
                    grant_d = 3'b000;
                    cmd_d   = 4'b0000;
                    ack_d   = grant_q;
                    terr_d  = terr_q | ~bus.eng_done;
                end
            end
            ACK: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end
    // State and registered outputs with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            rr_last_q <= 2'd2;
            cnt_q     <= 16'd0;
            grant_q   <= 3'b000;
            ack_q     <= 3'b000;
            cmd_q     <= 4'b0000;
            px_q      <= 8'd0;
            py_q      <= 8'd0;
            busy_q    <= 1'b0;
            terr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_last_q <= rr_last_d;
            cnt_q     <= cnt_d;
            grant_q   <= grant_d;
            ack_q     <= ack_d;
            cmd_q     <= cmd_d;
            px_q      <= px_d;
            py_q      <= py_d;
            busy_q    <= busy_d;
            terr_q    <= terr_d;
        end
    end
    assign bus.grant       = grant_q;
    assign bus.ack         = ack_q;
    assign bus.eng_cmd     = cmd_q;
    assign bus.eng_px      = px_q;
    assign bus.eng_py      = py_q;
    assign bus.busy        = busy_q;
    assign bus.timeout_err = terr_q;
endmodule

// File: tb/tb_draw_sched.sv
// tb_draw_sched: directed scenario tests of draw_sched
module tb_draw_sched;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int failures = 0;
    draw_sched_if bus_a();
    draw_sched_if bus_b();
    draw_sched #(.TIMEOUT(100)) u_a (.clk(clk), .reset(reset), .bus(bus_a));
    draw_sched #(.TIMEOUT(20))  u_b (.clk(clk), .reset(reset), .bus(bus_b));
    always #5 clk = ~clk;
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        checks++;
        if ({bus_a.grant, bus_a.ack, bus_a.eng_cmd, bus_a.eng_px, bus_a.eng_py, bus_a.busy, bus_a.timeout_err} !== 28'd0) begin
            failures++;
            $display("FAIL reset_outputs got grant=%b ack=%b cmd=%b px=%0d py=%0d busy=%b terr=%b exp all zero",
                     bus_a.grant, bus_a.ack, bus_a.eng_cmd, bus_a.eng_px, bus_a.eng_py, bus_a.busy, bus_a.timeout_err);
        end
    endtask
    task automatic test_single_job();
        bus_a.req = 3'b001;
        bus_a.req_kind = 6'b000010;
        tick();
        checks++;
        if (bus_a.grant !== 3'b001 || bus_a.eng_cmd !== 4'b0100 || bus_a.busy !== 1'b1) begin
            failures++;
            $display("FAIL single_start got grant=%b cmd=%b busy=%b exp 001 0100 1", bus_a.grant, bus_a.eng_cmd, bus_a.busy);
        end
        repeat (50) tick();
        checks++;
        if (bus_a.eng_cmd !== 4'b0100 || bus_a.ack !== 3'b000) begin
            failures++;
            $display("FAIL single_hold got cmd=%b ack=%b exp 0100 000", bus_a.eng_cmd, bus_a.ack);
        end
        bus_a.eng_done = 1'b1;
        tick();
        bus_a.eng_done = 1'b0;
        bus_a.req = 3'b000;
        checks++;
        if (bus_a.eng_cmd !== 4'b0000 || bus_a.ack !== 3'b001 || bus_a.grant !== 3'b000 || bus_a.busy !== 1'b1) begin
            failures++;
            $display("FAIL single_ack got cmd=%b ack=%b grant=%b busy=%b exp 0000 001 000 1",
                     bus_a.eng_cmd, bus_a.ack, bus_a.grant, bus_a.busy);
        end
        tick();
        checks++;
        if (bus_a.ack !== 3'b000 || bus_a.busy !== 1'b0 || bus_a.eng_cmd !== 4'b0000) begin
            failures++;
            $display("FAIL single_idle got ack=%b busy=%b cmd=%b exp 000 0 0000", bus_a.ack, bus_a.busy, bus_a.eng_cmd);
        end
    endtask
    task automatic test_done_in_idle();
        bus_a.eng_done = 1'b1;
        tick();
        bus_a.eng_done = 1'b0;
        tick();
        checks++;
        if (bus_a.ack !== 3'b000 || bus_a.busy !== 1'b0 || bus_a.eng_cmd !== 4'b0000) begin
            failures++;
            $display("FAIL idle_done got ack=%b busy=%b cmd=%b exp 000 0 0000", bus_a.ack, bus_a.busy, bus_a.eng_cmd);
        end
    endtask
    task automatic test_origin_latch();
        bus_a.req = 3'b010;
        bus_a.req_kind = 6'b000000;
        bus_a.req_px = {8'd0, 8'd37, 8'd0};
        bus_a.req_py = {8'd0, 8'd90, 8'd0};
        tick();
        checks++;
        if (bus_a.eng_px !== 8'd37 || bus_a.eng_py !== 8'd90 || bus_a.eng_cmd !== 4'b0001 || bus_a.grant !== 3'b010) begin
            failures++;
            $display("FAIL origin_latch got px=%0d py=%0d cmd=%b grant=%b exp 37 90 0001 010",
                     bus_a.eng_px, bus_a.eng_py, bus_a.eng_cmd, bus_a.grant);
        end
        bus_a.req_px = {8'd0, 8'd5, 8'd0};
        bus_a.req_kind = 6'b001100;
        bus_a.req = 3'b000;
        repeat (3) tick();
        checks++;
        if (bus_a.eng_px !== 8'd37 || bus_a.eng_cmd !== 4'b0001 || bus_a.grant !== 3'b010) begin
            failures++;
            $display("FAIL origin_hold got px=%0d cmd=%b grant=%b exp 37 0001 010", bus_a.eng_px, bus_a.eng_cmd, bus_a.grant);
        end
        bus_a.eng_done = 1'b1;
        tick();
        bus_a.eng_done = 1'b0;
        checks++;
        if (bus_a.ack !== 3'b010) begin
            failures++;
            $display("FAIL origin_ack got ack=%b exp 010", bus_a.ack);
        end
        tick();
    endtask
    task automatic test_round_robin();
        logic [2:0] exp_grant [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
        test_reset();
        bus_a.req = 3'b111;
        bus_a.req_kind = 6'b000000;
        tick();
        for (int j = 0; j < 4; j++) begin
            int gap = 0;
            while (bus_a.eng_cmd === 4'b0000 && gap < 10) begin
                tick();
                gap++;
            end
            checks++;
            if (bus_a.grant !== exp_grant[j]) begin
                failures++;
                $display("FAIL rr_grant%0d got=%b exp=%b", j, bus_a.grant, exp_grant[j]);
            end
            if (j > 0) begin
                checks++;
                if (gap != 2) begin
                    failures++;
                    $display("FAIL rr_gap%0d got=%0d exp=2", j, gap);
                end
            end
            repeat (9) tick();
            bus_a.eng_done = 1'b1;
            tick();
            bus_a.eng_done = 1'b0;
            checks++;
            if (bus_a.ack !== exp_grant[j]) begin
                failures++;
                $display("FAIL rr_ack%0d got=%b exp=%b", j, bus_a.ack, exp_grant[j]);
            end
        end
        bus_a.req = 3'b000;
        tick();
        tick();
    endtask
    task automatic test_timeout();
        int n = 0;
        bus_a.req = 3'b100;
        bus_a.req_kind = 6'b110000;
        tick();
        while (bus_a.eng_cmd === 4'b1000 && n < 200) begin
            n++;
            tick();
        end
        bus_a.req = 3'b000;
        checks++;
        if (n != 100) begin
            failures++;
            $display("FAIL timeout_len got=%0d exp=100", n);
        end
        checks++;
        if (bus_a.ack !== 3'b100 || bus_a.timeout_err !== 1'b1) begin
            failures++;
            $display("FAIL timeout_ack got ack=%b terr=%b exp 100 1", bus_a.ack, bus_a.timeout_err);
        end
        tick();
        bus_a.req = 3'b001;
        bus_a.req_kind = 6'b000000;
        tick();
        checks++;
        if (bus_a.eng_cmd !== 4'b0001 || bus_a.timeout_err !== 1'b1) begin
            failures++;
            $display("FAIL timeout_sticky_busy got cmd=%b terr=%b exp 0001 1", bus_a.eng_cmd, bus_a.timeout_err);
        end
        bus_a.eng_done = 1'b1;
        tick();
        bus_a.eng_done = 1'b0;
        bus_a.req = 3'b000;
        checks++;
        if (bus_a.ack !== 3'b001 || bus_a.timeout_err !== 1'b1) begin
            failures++;
            $display("FAIL timeout_sticky_ack got ack=%b terr=%b exp 001 1", bus_a.ack, bus_a.timeout_err);
        end
        tick();
    endtask
    task automatic test_reset_mid_job();
        bus_a.req = 3'b010;
        bus_a.req_kind = 6'b000100;
        tick();
        repeat (4) tick();
        checks++;
        if (bus_a.eng_cmd !== 4'b0010 || bus_a.grant !== 3'b010) begin
            failures++;
            $display("FAIL rst_mid_busy got cmd=%b grant=%b exp 0010 010", bus_a.eng_cmd, bus_a.grant);
        end
        reset = 1'b1;
        tick();
        checks++;
        if ({bus_a.grant, bus_a.ack, bus_a.eng_cmd, bus_a.eng_px, bus_a.eng_py, bus_a.busy, bus_a.timeout_err} !== 28'd0) begin
            failures++;
            $display("FAIL rst_mid_outputs got grant=%b ack=%b cmd=%b busy=%b terr=%b exp all zero",
                     bus_a.grant, bus_a.ack, bus_a.eng_cmd, bus_a.busy, bus_a.timeout_err);
        end
        reset = 1'b0;
        bus_a.req = 3'b011;
        bus_a.req_kind = 6'b000011;
        tick();
        checks++;
        if (bus_a.grant !== 3'b001 || bus_a.eng_cmd !== 4'b1000) begin
            failures++;
            $display("FAIL rst_mid_regrant got grant=%b cmd=%b exp 001 1000", bus_a.grant, bus_a.eng_cmd);
        end
        bus_a.eng_done = 1'b1;
        tick();
        bus_a.eng_done = 1'b0;
        bus_a.req = 3'b000;
        checks++;
        if (bus_a.ack !== 3'b001) begin
            failures++;
            $display("FAIL rst_mid_ack got=%b exp=001", bus_a.ack);
        end
        tick();
    endtask
    task automatic test_done_timeout_race();
        bus_b.req = 3'b001;
        bus_b.req_kind = 6'b000001;
        tick();
        repeat (19) tick();
        checks++;
        if (bus_b.eng_cmd !== 4'b0010 || bus_b.ack !== 3'b000) begin
            failures++;
            $display("FAIL race_cycle20 got cmd=%b ack=%b exp 0010 000", bus_b.eng_cmd, bus_b.ack);
        end
        bus_b.eng_done = 1'b1;
        tick();
        bus_b.eng_done = 1'b0;
        bus_b.req = 3'b000;
        checks++;
        if (bus_b.ack !== 3'b001 || bus_b.timeout_err !== 1'b0 || bus_b.eng_cmd !== 4'b0000) begin
            failures++;
            $display("FAIL race_result got ack=%b terr=%b cmd=%b exp 001 0 0000", bus_b.ack, bus_b.timeout_err, bus_b.eng_cmd);
        end
        tick();
    endtask
    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end
    initial begin
        bus_a.req = 3'b000;
        bus_a.req_kind = 6'b000000;
        bus_a.req_px = 24'd0;
        bus_a.req_py = 24'd0;
        bus_a.eng_done = 1'b0;
        bus_b.req = 3'b000;
        bus_b.req_kind = 6'b000000;
        bus_b.req_px = 24'd0;
        bus_b.req_py = 24'd0;
        bus_b.eng_done = 1'b0;
        test_reset();
        test_single_job();
        test_done_in_idle();
        test_origin_latch();
        test_round_robin();
        test_timeout();
        test_reset_mid_job();
        test_done_timeout_race();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
